// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM encoding,
// default operand width and the shift-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
// Purely combinational; the serial adder instantiates exactly one.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  assign ha1_s = a ^ b;
  assign ha1_c = a & b;
  assign s     = ha1_s ^ ci;
  assign ha2_c = ha1_s & ci;
  assign co    = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg, ovf_next;
`endif

  logic fa_s;
  logic fa_co;

  fa_cell u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          a_next     = a_in;
          b_next     = b_in;
          carry_next = c_in;
          cnt_next   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_next   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH edges bit 0 lands at sum[0].
        sum_next   = {fa_s, sum_reg[WIDTH-1:1]};
        a_next     = a_reg >> 1;
        b_next     = b_reg >> 1;
        carry_next = fa_co;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_next   = carry_reg ^ fa_co;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg == SHIFT);
  assign done  = (state_reg == DONE);
  assign sum   = sum_reg;
  assign c_out = carry_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    int           done_cyc;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .c_out (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_sum"}, 32'(sum), 32'(e.sum));
        check({e.name, "_cout"}, 32'(c_out), 32'(e.c_out));
        check({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
`ifdef SERIAL_ADDER_OVF_EN
        check({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        $display("txn %s: sum=%02h c_out=%0b at cycle %0d", e.name, sum, c_out, cyc);
      end
    end
  end

  // Raise start for one edge and queue the hand-computed result.
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; c_in = ci; start = 1'b1;
    e.sum = es; e.c_out = ec; e.ovf = eo; e.name = name;
    e.done_cyc = cyc + 1 + W;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_in = ~a; b_in = ~b; c_in = ~ci;
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 4 * W; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    issue(name, a, b, ci, es, ec, eo);
    wait_drain(name);
  endtask

  initial begin
    // Reset with garbage inputs and start held high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom); start = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    add("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_sum", 32'(sum), 32'h10);
    add("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    add("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    add("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    add("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Starts during SHIFT and DONE must be ignored.
    issue("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("ign_done_seen", 32'(done), 32'd1);
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("ign_busy_after_done", 32'(busy), 32'd0);
    repeat (W + 4) @(negedge clk);
    wait_drain("12+34");
    check("ign_sum_hold", 32'(sum), 32'h46);

    // Reset in the middle of AA+55: abort without a done pulse.
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    add("01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
